// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS control sequencer (Moore FSM + ALU decoder)
//
// Sequences fetch / decode / address-execute / memory / writeback for one
// instruction at a time. It drives the datapath mux selects and write enables
// for a shared memory and a shared ALU.
//
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN (adds instr_retired counter).
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   opcode, funct        instruction fields from the instruction register
//   mem_ready            memory finished the current access this cycle
//   mem_req, iord        memory request and address select (0=PC, 1=ALUOut)
//   memwrite, irwrite    memory write strobe, instruction register load
//   regdst, memtoreg     register file destination / writeback data selects
//   regwrite             register file write
//   alusrca, alusrcb     ALU operand selects
//   pcsrc, pcwrite       PC source select, unconditional PC load
//   branch               PC load qualified by zero flag in the datapath
//   alucontrol           3-bit ALU operation
//   illegal_op           one-cycle pulse in DECODE for an undecoded opcode
//   instr_retired        retired-instruction count (macro only)
//   state                current state (debug)
module multicycle_control_fsm #(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic               pcwrite,
    output logic               branch,
    output logic [2:0]         alucontrol,
    output logic               illegal_op,
`ifdef MULTICYCLE_CTRL_PERF_EN
    output logic [CNT_W-1:0]   instr_retired,
`endif
    output logic [STATE_W-1:0] state
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECUTE  = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_ADDIEX   = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_ADDIWB   = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_JUMP     = STATE_W'(11);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [STATE_W-1:0] state_q, state_d;
    logic               is_sw_q;
    logic [1:0]         aluop;

    // State register. The lw/sw distinction is captured in DECODE so that the
    // opcode is not looked at again in MEMADR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                is_sw_q <= (opcode == OP_SW);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = is_sw_q ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEX:   state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Output logic (Moore, except FETCH enables which follow mem_ready)
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        aluop      = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                    default:                                      illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        // Held reset suppresses every side effect so an abandoned instruction
        // cannot write anything in the cycle before the reset edge lands.
        if (!rst_n) begin
            mem_req    = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            pcwrite    = 1'b0;
            branch     = 1'b0;
            illegal_op = 1'b0;
        end
    end

    // ALU decoder
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b100;
            2'b10: begin
                case (funct)
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b100;
                    6'b101010: alucontrol = 3'b110;
                    6'b011100: alucontrol = 3'b101;
                    default:   alucontrol = 3'b111;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    // Completed instructions only; the illegal-opcode DECODE->FETCH return is excluded.
    always_comb begin
        case (state_q)
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
            S_MEMWRITE:                                   retire = mem_ready;
            default:                                      retire = 1'b0;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign instr_retired = retired_q;
`endif

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard testbench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    localparam int ST = 0, MREQ = 1, IORD = 2, MWR = 3, IRW = 4, RDST = 5, M2R = 6, RWR = 7;
    localparam int ASA = 8, ASB = 9, PCS = 10, PCW = 11, BR = 12, ALU = 13, ILL = 14, RET = 15;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       mem_ready;
    logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcwrite, branch, illegal_op;
    logic [2:0] alucontrol;
    logic [3:0] state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [3:0] instr_retired;
`endif

    multicycle_control_fsm #(.STATE_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .pcwrite(pcwrite), .branch(branch),
        .alucontrol(alucontrol), .illegal_op(illegal_op),
`ifdef MULTICYCLE_CTRL_PERF_EN
        .instr_retired(instr_retired),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int id;
        int val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int get_sig(input int id);
        case (id)
            ST:   return int'(state);
            MREQ: return int'(mem_req);
            IORD: return int'(iord);
            MWR:  return int'(memwrite);
            IRW:  return int'(irwrite);
            RDST: return int'(regdst);
            M2R:  return int'(memtoreg);
            RWR:  return int'(regwrite);
            ASA:  return int'(alusrca);
            ASB:  return int'(alusrcb);
            PCS:  return int'(pcsrc);
            PCW:  return int'(pcwrite);
            BR:   return int'(branch);
            ALU:  return int'(alucontrol);
            ILL:  return int'(illegal_op);
`ifdef MULTICYCLE_CTRL_PERF_EN
            RET:  return int'(instr_retired);
`endif
            default: return -1;
        endcase
    endfunction

    function automatic string sig_name(input int id);
        case (id)
            ST:   return "state";
            MREQ: return "mem_req";
            IORD: return "iord";
            MWR:  return "memwrite";
            IRW:  return "irwrite";
            RDST: return "regdst";
            M2R:  return "memtoreg";
            RWR:  return "regwrite";
            ASA:  return "alusrca";
            ASB:  return "alusrcb";
            PCS:  return "pcsrc";
            PCW:  return "pcwrite";
            BR:   return "branch";
            ALU:  return "alucontrol";
            ILL:  return "illegal_op";
            RET:  return "instr_retired";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: compares every expectation registered for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            int   act;
            e = sb.pop_front();
            act = get_sig(e.id);
            n_cmp++;
            if (e.cyc != cyc || act != e.val) begin
                n_bad++;
                $display("FAIL %s cycle %0d (checked at %0d): got %0d expected %0d",
                         sig_name(e.id), e.cyc, cyc, act, e.val);
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic mr);
        @(posedge clk);
        #1;
        rst_n     = r;
        opcode    = op;
        funct     = fn;
        mem_ready = mr;
        cyc++;
    endtask

    task automatic e(input int id, input int val);
        exp_t x;
        x.cyc = cyc;
        x.id  = id;
        x.val = val;
        sb.push_back(x);
    endtask

    task automatic e_ret(input int val);
`ifdef MULTICYCLE_CTRL_PERF_EN
        e(RET, val);
`else
        if (val < 0) e(ST, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; opcode = LW; funct = 6'd0; mem_ready = 1'b1;

        // Reset held two edges: side effects suppressed
        step(0, LW, 0, 1); e(ST, 0); e(IRW, 0); e(PCW, 0); e(MREQ, 0); e(RWR, 0); e(MWR, 0);
        step(0, LW, 0, 1); e(ST, 0); e(IRW, 0); e(MWR, 0);
        // lw: 0,1,2,3,4,0
        step(1, LW, 0, 1); e(ST, 0); e(IRW, 1); e(PCW, 1); e(MREQ, 1); e(ASB, 1); e(ALU, 2);
        step(1, LW, 0, 1); e(ST, 1); e(ASB, 3); e(IRW, 0); e(PCW, 0); e(ALU, 2);
        step(1, LW, 0, 1); e(ST, 2); e(ASB, 2); e(ASA, 1); e(ALU, 2);
        step(1, LW, 0, 1); e(ST, 3); e(MREQ, 1); e(IORD, 1);
        step(1, LW, 0, 1); e(ST, 4); e(M2R, 1); e(RWR, 1); e(RDST, 0);
        // R-type slt then mul-style funct
        step(1, RT, 6'b101010, 1); e(ST, 0); e_ret(1);
        step(1, RT, 6'b101010, 1); e(ST, 1);
        step(1, RT, 6'b101010, 1); e(ST, 6); e(ALU, 6); e(ASA, 1); e(ASB, 0);
        step(1, RT, 6'b101010, 1); e(ST, 7); e(RDST, 1); e(RWR, 1);
        step(1, RT, 6'b011100, 1); e(ST, 0); e_ret(2);
        step(1, RT, 6'b011100, 1); e(ST, 1);
        step(1, RT, 6'b011100, 1); e(ST, 6); e(ALU, 5);
        step(1, RT, 6'b011100, 1); e(ST, 7); e(RDST, 1);
        // Unknown funct, then reset lands in ALUWB: no writeback
        step(1, RT, 6'b111111, 1); e(ST, 0); e_ret(3);
        step(1, RT, 6'b111111, 1); e(ST, 1);
        step(1, RT, 6'b111111, 1); e(ST, 6); e(ALU, 7);
        step(0, RT, 6'b111111, 1); e(ST, 7); e(RWR, 0); e(MREQ, 0); e(RDST, 1);
        // sw with three wait cycles in MEMWRITE
        step(1, SW, 0, 1); e(ST, 0); e_ret(0);
        step(1, SW, 0, 1); e(ST, 1);
        step(1, SW, 0, 1); e(ST, 2); e(ASB, 2);
        step(1, SW, 0, 0); e(ST, 5); e(MWR, 1); e(MREQ, 1); e(IORD, 1);
        step(1, SW, 0, 0); e(ST, 5); e(MWR, 1);
        step(1, SW, 0, 0); e(ST, 5); e(MWR, 1);
        step(1, SW, 0, 1); e(ST, 5); e(MWR, 1);
        // FETCH stalled two cycles, then beq
        step(1, BEQ, 0, 0); e(ST, 0); e(PCW, 0); e(IRW, 0); e(MREQ, 1); e_ret(1);
        step(1, BEQ, 0, 0); e(ST, 0); e(PCW, 0);
        step(1, BEQ, 0, 1); e(ST, 0); e(PCW, 1); e(IRW, 1);
        step(1, BEQ, 0, 1); e(ST, 1); e(PCW, 0);
        step(1, BEQ, 0, 1); e(ST, 8); e(BR, 1); e(PCS, 1); e(ALU, 4); e(ASA, 1); e(ASB, 0);
        // j
        step(1, JMP, 0, 1); e(ST, 0); e(BR, 0); e_ret(2);
        step(1, JMP, 0, 1); e(ST, 1);
        step(1, JMP, 0, 1); e(ST, 11); e(PCW, 1); e(PCS, 2);
        // Illegal opcode: single pulse, not retired
        step(1, BAD, 0, 1); e(ST, 0); e(ILL, 0); e_ret(3);
        step(1, BAD, 0, 1); e(ST, 1); e(ILL, 1);
        // addi
        step(1, ADDI, 0, 1); e(ST, 0); e(ILL, 0); e_ret(3);
        step(1, ADDI, 0, 1); e(ST, 1); e(ILL, 0);
        step(1, ADDI, 0, 1); e(ST, 9); e(ASB, 2); e(ASA, 1); e(ALU, 2);
        step(1, ADDI, 0, 1); e(ST, 10); e(RWR, 1); e(RDST, 0); e(M2R, 0);
        step(1, JMP, 0, 1); e(ST, 0); e_ret(4);
        // Twelve jumps: 4-bit counter reaches 15 then wraps to 0
        for (int i = 0; i < 12; i++) begin
            step(1, JMP, 0, 1); e(ST, 1);
            step(1, JMP, 0, 1); e(ST, 11);
            step(1, JMP, 0, 1); e(ST, 0);
            if (i == 10) e_ret(15);
            if (i == 11) e_ret(0);
        end

        step(1, JMP, 0, 0);
        step(1, JMP, 0, 0);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
